// File: rtl/rv32i_types.sv
// Shared RV32I memory-access types: funct3 width codes, fault causes and store beat payload.
package rv32i_types;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_ILLEGAL    = 2'd2,
    FAULT_TIMEOUT    = 2'd3
  } fault_cause_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [BE_W-1:0] be;
  } store_beat_t;

  // Decode-time legality of a CPU request; timeouts are decided later.
  function automatic fault_cause_e check_access(input logic rd, input logic wr,
                                                input logic [2:0] f3, input logic [1:0] lo);
    fault_cause_e c;
    c = FAULT_NONE;
    if (rd && wr) begin
      c = FAULT_ILLEGAL;
    end else begin
      case (f3)
        F3_B:  c = FAULT_NONE;
        F3_H:  c = lo[0] ? FAULT_MISALIGNED : FAULT_NONE;
        F3_W:  c = (lo != 2'b00) ? FAULT_MISALIGNED : FAULT_NONE;
        F3_BU: c = wr ? FAULT_ILLEGAL : FAULT_NONE;
        F3_HU: c = wr ? FAULT_ILLEGAL : (lo[0] ? FAULT_MISALIGNED : FAULT_NONE);
        default: c = FAULT_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_write,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output store_beat_t     store_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_c = {24'd0, byte_sel};
      F3_HU:   load_data_c = {16'd0, half_sel};
      default: load_data_c = rdata;
    endcase
  end

  always_comb begin
    store_c.data = wdata;
    store_c.be   = 4'b1111;
    if (is_write) begin
      case (funct3[1:0])
        2'b00: begin
          store_c.data = {4{wdata[7:0]}};
          store_c.be   = 4'b0001 << addr_lo;
        end
        2'b01: begin
          store_c.data = {2{wdata[15:0]}};
          store_c.be   = 4'b0011 << addr_lo;
        end
        default: begin
          store_c.data = wdata;
          store_c.be   = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// CPU load/store to word-oriented memory bridge with alignment faults and response timeout.
module mem_bridge
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_address,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_resp,
  output logic            mem_fault,
  output logic [1:0]      fault_cause,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [XLEN-1:0] pmem_address,
  output logic [XLEN-1:0] pmem_wdata,
  output logic [BE_W-1:0] pmem_byte_enable,
  input  logic [XLEN-1:0] pmem_rdata,
  input  logic            pmem_resp
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FLUSH} state_e;

  state_e             state;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         addr_lo_q;
  logic [2:0]         funct3_q;
  logic               is_write_q;

  logic               in_idle;
  fault_cause_e       req_fault_c;
  store_beat_t        store_c;
  logic [XLEN-1:0]    load_data_c;

  // One aligner serves both paths: request inputs while idle, latched access otherwise.
  assign in_idle     = (state == IDLE);
  assign req_fault_c = check_access(mem_read, mem_write, mem_funct3, mem_address[1:0]);

  mem_align u_align (
    .funct3      (in_idle ? mem_funct3 : funct3_q),
    .addr_lo     (in_idle ? mem_address[1:0] : addr_lo_q),
    .is_write    (in_idle ? mem_write : is_write_q),
    .wdata       (mem_wdata),
    .rdata       (pmem_rdata),
    .store_c     (store_c),
    .load_data_c (load_data_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      timer            <= '0;
      addr_lo_q        <= '0;
      funct3_q         <= '0;
      is_write_q       <= 1'b0;
      mem_rdata        <= '0;
      mem_resp         <= 1'b0;
      mem_fault        <= 1'b0;
      fault_cause      <= FAULT_NONE;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_lo_q  <= mem_address[1:0];
            funct3_q   <= mem_funct3;
            is_write_q <= mem_write;
            if (req_fault_c != FAULT_NONE) begin
              state       <= DONE;
              mem_resp    <= 1'b1;
              mem_fault   <= 1'b1;
              fault_cause <= req_fault_c;
            end else begin
              state            <= REQ;
              timer            <= '0;
              pmem_read        <= ~mem_write;
              pmem_write       <= mem_write;
              pmem_address     <= {mem_address[XLEN-1:2], 2'b00};
              pmem_wdata       <= store_c.data;
              pmem_byte_enable <= store_c.be;
            end
          end
        end
        REQ: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            if (!is_write_q) mem_rdata <= load_data_c;
          end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= DONE;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            mem_resp    <= 1'b1;
            mem_fault   <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        DONE: begin
          mem_resp    <= 1'b0;
          mem_fault   <= 1'b0;
          fault_cause <= FAULT_NONE;
          // A timed-out access may still see its late response; drain it first.
          state       <= (fault_cause == FAULT_TIMEOUT) ? FLUSH : IDLE;
        end
        FLUSH: begin
          if (!pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized scoreboard bench for mem_bridge against an arithmetic access model.
module tb_mem_bridge;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp, mem_fault;
  logic [1:0]  fault_cause;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .mem_fault(mem_fault), .fault_cause(fault_cause),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          stale;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 0;
  bit    auto_en = 0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [1:0] model_cause(input bit rd, input bit wr, input int f3,
                                             input logic [31:0] addr);
    if (rd && wr) return 2'd2;
    if (wr && !(f3 inside {0, 1, 2})) return 2'd2;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) return 2'd2;
    if ((addr % acc_size(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz;
    logic [31:0] v, mask;
    sz = acc_size(f3);
    if (sz == 4) return word;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (word >> (8 * (addr % 4))) & mask;
    if (f3 < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_txn(input bit rd, input bit wr, input int f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int delay, input int stale);
    exp_t e;
    plan_t p;
    logic [1:0] cause;
    bit to;
    int lat, exp_lat, sz;
    cause = model_cause(rd, wr, f3, addr);
    to = (cause == 2'd0) && (delay >= T);
    if (cause == 2'd0 && !to && rd) exp_rdata = model_load(f3, addr, rdata);
    e.fault = (cause != 2'd0) || to;
    e.cause = to ? 2'd3 : cause;
    e.rdata = exp_rdata;
    if (cause == 2'd0) begin
      sz = acc_size(f3);
      p.rd    = rd;
      p.addr  = addr & 32'hFFFF_FFFC;
      p.be    = rd ? 4'hF : 4'((((1 << sz) - 1) << (addr % 4)));
      p.wdata = (sz == 1) ? wdata[7:0] * 32'h0101_0101 :
                (sz == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
      p.rdata = rdata;
      p.delay = delay;
      p.stale = stale;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_funct3 = 3'(f3);
    mem_address = addr; mem_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < T + 20);
    exp_lat = (cause != 2'd0) ? 1 : (to ? T + 1 : delay + 2);
    check("resp_latency", lat, exp_lat);
    mem_read = 0; mem_write = 0;
    mem_address = $urandom; mem_wdata = $urandom;
    repeat (to ? stale + 3 : int'($urandom_range(0, 2))) @(negedge clk);
  endtask

  // Monitor: every completion pulse is matched against the scoreboard.
  initial begin : monitor
    exp_t e;
    bit prev_resp;
    prev_resp = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_resp) begin
          check("resp_single_cycle", 32'(prev_resp), 32'd0);
          if (exp_q.size() == 0) begin
            check("resp_spurious", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("mem_fault", 32'(mem_fault), 32'(e.fault));
            check("fault_cause", 32'(fault_cause), 32'(e.cause));
            check("mem_rdata", mem_rdata, e.rdata);
          end
        end else if (mem_fault || fault_cause != 2'd0) begin
          check("fault_outside_resp", {mem_fault, fault_cause}, 32'd0);
        end
      end
      prev_resp = mem_resp;
    end
  end

  // Memory model: answers each planned pmem access and checks its payload.
  initial begin : responder
    plan_t p;
    int i;
    pmem_resp = 0;
    pmem_rdata = $urandom;
    forever begin
      @(negedge clk);
      if (mon_en && auto_en) begin
        if (pmem_read && pmem_write) check("pmem_both_high", 32'd1, 32'd0);
        if (pmem_read || pmem_write) begin
          if (plan_q.size() == 0) begin
            check("pmem_unexpected", 32'd1, 32'd0);
          end else begin
            p = plan_q.pop_front();
            i = 0;
            forever begin
              check("pmem_read", 32'(pmem_read), 32'(p.rd));
              check("pmem_write", 32'(pmem_write), 32'(!p.rd));
              check("pmem_address", pmem_address, p.addr);
              check("pmem_byte_enable", 32'(pmem_byte_enable), 32'(p.be));
              if (!p.rd) check("pmem_wdata", pmem_wdata, p.wdata);
              if (i == p.delay) begin
                pmem_rdata = p.rdata;
                pmem_resp = 1;
                @(negedge clk);
                pmem_resp = 0;
                pmem_rdata = $urandom;
                break;
              end
              @(negedge clk);
              i++;
              if (!(pmem_read || pmem_write)) break;
            end
            if (p.delay >= T) begin
              check("pmem_high_cycles", i, T);
              pmem_resp = 1;
              repeat (p.stale) @(negedge clk);
              pmem_resp = 0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit rd, wr;
    int f3, sz, sel, delay;
    logic [31:0] addr;
    rst = 0;
    mem_read = 0; mem_write = 0; mem_funct3 = 0; mem_address = 0; mem_wdata = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(|{mem_rdata, mem_resp, mem_fault, fault_cause, pmem_read,
                                  pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}), 32'd0);
    rst = 1;
    mon_en = 1;
    auto_en = 1;

    run_txn(1, 0, 2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
    run_txn(1, 0, 0, 32'h103, 32'h0, 32'h80FF0011, 1, 0);
    run_txn(1, 0, 4, 32'h103, 32'h0, 32'h80FF0011, 0, 0);
    run_txn(1, 0, 5, 32'h102, 32'h0, 32'h80FF0011, 2, 0);
    run_txn(1, 0, 1, 32'h102, 32'h0, 32'h80FF0011, 0, 0);
    run_txn(0, 1, 1, 32'h206, 32'h1234ABCD, 32'h0, 4, 0);
    run_txn(0, 1, 0, 32'h301, 32'hA5A5A55A, 32'h0, 1, 0);
    run_txn(1, 0, 2, 32'h102, 32'h0, 32'h0, 0, 0);
    run_txn(0, 1, 1, 32'h205, 32'h1, 32'h0, 0, 0);
    run_txn(1, 0, 2, 32'h110, 32'h0, 32'h12345678, T, 3);
    run_txn(1, 0, 2, 32'h114, 32'h0, 32'hCAFEF00D, T - 1, 0);
    run_txn(1, 1, 2, 32'h120, 32'h0, 32'h0, 0, 0);
    run_txn(1, 0, 3, 32'h120, 32'h0, 32'h0, 0, 0);
    run_txn(0, 1, 4, 32'h120, 32'h0, 32'h0, 0, 0);
    run_txn(0, 1, 2, 32'h124, 32'h0BADF00D, 32'h0, T + 2, 1);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      rd = (sel < 10) || (sel == 19);
      wr = (sel >= 10);
      if ($urandom_range(0, 9) == 0) f3 = $urandom_range(0, 7);
      else if (wr) f3 = $urandom_range(0, 2);
      else begin
        f3 = $urandom_range(0, 4);
        if (f3 == 3) f3 = 5;
      end
      sz = acc_size(f3);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr = addr - (addr % sz);
      delay = ($urandom_range(0, 19) == 0) ? T + int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 5));
      run_txn(rd, wr, f3, addr, $urandom, $urandom, delay, $urandom_range(1, 3));
    end

    // Reset in the middle of an outstanding access.
    repeat (3) @(negedge clk);
    auto_en = 0;
    mem_read = 1; mem_funct3 = 3'd2; mem_address = 32'h100;
    for (int k = 0; k < 5 && !pmem_read; k++) @(negedge clk);
    check("rst_req_pmem_read", 32'(pmem_read), 32'd1);
    rst = 0;
    mem_read = 0;
    @(negedge clk);
    check("rst_mid_req_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_mid_req_outputs", 32'(|{mem_rdata, mem_resp, mem_fault, fault_cause, pmem_read,
                                        pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}), 32'd0);
    rst = 1;
    pmem_resp = 1;
    repeat (2) @(negedge clk);
    pmem_resp = 0;
    repeat (4) @(negedge clk);
    check("post_rst_outputs", 32'(|{mem_rdata, mem_resp, mem_fault, fault_cause, pmem_read,
                                     pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}), 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("plan_drained", plan_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
